// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared FSM state type and width-generic LFSR/MISR next-state functions
package bist_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {IDLE, INIT, RUN, COMPARE, DONE} state_t;

    // wmask has ones in the low W bits; callers zero-extend operands to MAX_W.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s,
                                                   input logic [MAX_W-1:0] poly,
                                                   input logic [MAX_W-1:0] wmask);
        return ((s << 1) | MAX_W'(^(s & poly))) & wmask;
    endfunction

    function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] s,
                                                   input logic [MAX_W-1:0] poly,
                                                   input logic [MAX_W-1:0] d,
                                                   input logic [MAX_W-1:0] wmask);
        logic msb;
        msb = |(s & wmask & ~(wmask >> 1));
        return ((s << 1) ^ (msb ? poly : '0) ^ d) & wmask;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - multiple-input signature register compacting the CUT response
module bist_misr
    import bist_pkg::*;
#(
    parameter int                MISR_W    = 8,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(8'h1D)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [MISR_W-1:0] data,
    output logic [MISR_W-1:0] signature
);

    localparam logic [MAX_W-1:0] W_MASK = {MAX_W{1'b1}} >> (MAX_W - MISR_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signature <= '0;
        end else if (clear) begin
            signature <= '0;
        end else if (enable) begin
            signature <= MISR_W'(misr_next(MAX_W'(signature), MAX_W'(MISR_POLY),
                                           MAX_W'(data), W_MASK));
        end
    end

endmodule

// File: rtl/bist_engine.sv
// rtl/bist_engine.sv - logic-BIST controller: LFSR pattern source, MISR compaction, golden compare
// Optional signature readback port enabled by BIST_SIG_OUT_EN.
module bist_engine
    import bist_pkg::*;
#(
    parameter int                MISR_W     = 8,
    parameter int                TPG_W      = 8,
    parameter int                N_PAT      = 255,
    parameter logic [TPG_W-1:0]  TPG_POLY   = TPG_W'(8'hB8),
    parameter logic [TPG_W-1:0]  TPG_SEED   = TPG_W'(8'h01),
    parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(8'h1D),
    parameter logic [MISR_W-1:0] GOLDEN_SIG = MISR_W'(8'h00)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MISR_W-1:0] cut_resp,
    output logic [TPG_W-1:0]  tpg_data,
    output logic              running,
    output logic              bist_end,
    output logic              out
`ifdef BIST_SIG_OUT_EN
    ,
    output logic [MISR_W-1:0] sig
`endif
);

    localparam int               CNT_W    = $clog2(N_PAT + 1);
    localparam logic [MAX_W-1:0] TPG_MASK = {MAX_W{1'b1}} >> (MAX_W - TPG_W);

    if (TPG_SEED == '0) begin : g_bad_seed
        $error("bist_engine: TPG_SEED must be nonzero");
    end

    state_t             state;
    logic               start_q;
    logic               start_edge;
    logic [TPG_W-1:0]   lfsr;
    logic [TPG_W-1:0]   lfsr_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               last_pat;
    logic [MISR_W-1:0]  misr;

    assign start_edge = start & ~start_q;
    assign lfsr_nxt   = TPG_W'(lfsr_next(MAX_W'(lfsr), MAX_W'(TPG_POLY), TPG_MASK));
    assign last_pat   = (cnt == CNT_W'(N_PAT - 1));

    bist_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == INIT),
        .enable    (state == RUN),
        .data      (cut_resp),
        .signature (misr)
    );

    // tpg_data is its own register so it can read 0 outside RUN while the LFSR keeps its seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            start_q  <= 1'b1;
            lfsr     <= TPG_SEED;
            cnt      <= '0;
            tpg_data <= '0;
            running  <= 1'b0;
            bist_end <= 1'b0;
            out      <= 1'b0;
`ifdef BIST_SIG_OUT_EN
            sig      <= '0;
`endif
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state   <= INIT;
                        running <= 1'b1;
                    end
                end
                INIT: begin
                    lfsr     <= TPG_SEED;
                    cnt      <= '0;
                    tpg_data <= TPG_SEED;
                    state    <= RUN;
                end
                RUN: begin
                    lfsr <= lfsr_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_pat) begin
                        tpg_data <= '0;
                        state    <= COMPARE;
                    end else begin
                        tpg_data <= lfsr_nxt;
                    end
                end
                COMPARE: begin
                    out      <= (misr == GOLDEN_SIG);
                    running  <= 1'b0;
                    bist_end <= 1'b1;
`ifdef BIST_SIG_OUT_EN
                    sig      <= misr;
`endif
                    state    <= DONE;
                end
                DONE: begin
                    if (start_edge) begin
                        state    <= INIT;
                        running  <= 1'b1;
                        bist_end <= 1'b0;
                        out      <= 1'b0;
`ifdef BIST_SIG_OUT_EN
                        sig      <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bist_engine.md
# bist_engine

Parametrised logic-BIST controller: a Fibonacci LFSR test-pattern generator drives an external circuit-under-test (CUT), and a MISR compacts the CUT response. The final signature is compared against a golden value, and a pass/fail result is reported. It is the generalised successor of the fixed-width start/run/end BIST top. It adds configurable widths, pattern count, polynomials and seed, start edge detection, re-run from DONE, and optional signature readback. It sits between the test-access logic (start, result flags) and the CUT input mux (`running` selects TPG data onto the CUT inputs).

## Interface
Parameters:
- TPG_W, 8, LFSR/pattern width (≥2)
- MISR_W, 8, MISR/response width (≥2)
- N_PAT, 255, patterns applied per run (≥1)
- TPG_POLY, 8'hB8, LFSR feedback tap mask (bit i set = bit i taps)
- TPG_SEED, 8'h01, LFSR seed; 0 is illegal (elaboration error)
- MISR_POLY, 8'h1D, MISR feedback mask
- GOLDEN_SIG, 8'h00, expected final signature

Ports:
- clk  in  1  system clock, all flops rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request, rising-edge detected
- cut_resp  in  MISR_W  CUT response (combinational from tpg_data)
- tpg_data  out  TPG_W  current pattern to CUT
- running  out  1  BIST active; CUT input mux select
- bist_end  out  1  run complete, result valid
- out  out  1  pass flag, 1 = signature matched
- sig  out  MISR_W  final signature (only with BIST_SIG_OUT_EN)

## Operation
- States: IDLE → INIT → RUN → COMPARE → DONE.
- Start edge: `start_q` register; `start_edge = start & ~start_q`. `start_q` resets to 1, so a start held high through reset release does not trigger.
- IDLE: on start_edge, go to INIT.
- INIT (1 cycle): LFSR ← TPG_SEED, MISR ← 0, pattern counter ← 0.
- RUN (N_PAT cycles): `tpg_data` = LFSR. Each cycle:
  - MISR ← {misr[W-2:0],1'b0} ^ (misr[W-1] ? MISR_POLY : 0) ^ cut_resp.
  - LFSR ← {lfsr[W-2:0], ^(lfsr & TPG_POLY)}.
  - Counter increments; on count N_PAT-1, go to COMPARE.
  - The first pattern applied is TPG_SEED.
- COMPARE (1 cycle): register `out` ← (misr == GOLDEN_SIG), then go to DONE.
- DONE: `bist_end`=1; `out` holds. On start_edge, go to INIT (re-run); `bist_end` and `out` clear.
- start_edge in INIT/RUN/COMPARE is ignored.
- Counter width: $clog2(N_PAT+1). No wrap inside a run.
- `tpg_data` is 0 outside RUN.

## Timing
- Reset values: state=IDLE, running=0, bist_end=0, out=0, tpg_data=0, LFSR=TPG_SEED, MISR=0, sig=0.
- Reset mid-run: immediate abort to IDLE, all outputs at reset values. A new start edge is needed to run again.
- start_edge sampled at edge t → INIT in cycle t+1.
- `running`=1 in cycles t+1 … t+N_PAT+2 (INIT+RUN+COMPARE, N_PAT+2 cycles).
- `bist_end` and `out` are valid from cycle t+N_PAT+3.
- All outputs are registered. No combinational path from start or cut_resp to any output.

## Configuration
- BIST_SIG_OUT_EN defined:
  - `sig` port exists; loaded with the MISR value in COMPARE and held in DONE.
  - Cleared on reset and on re-run INIT.
- BIST_SIG_OUT_EN undefined: no `sig` port; the MISR value is internal only.

## Structure
- Package `bist_pkg` holds:
  - the state enum (IDLE, INIT, RUN, COMPARE, DONE);
  - `lfsr_next` and `misr_next` functions, parametrised by width via mask argument.
- Sub-module `bist_misr` (MISR_W, MISR_POLY): clear, enable, data in, signature out.
- LFSR, counter and FSM stay in `bist_engine`.

## Test plan
- Seed/latency: TPG_W=4, TPG_POLY=4'b1100, TPG_SEED=4'b0001, N_PAT=15, loopback cut_resp=tpg_data; start edge at t.
  - running rises at t+1 and falls after t+17; bist_end rises at t+18.
  - tpg_data shows 15 distinct nonzero values, starting at 4'b0001.
- Pass: GOLDEN_SIG set to the bench-model signature for the loopback → out=1 and bist_end=1 in DONE. With BIST_SIG_OUT_EN, sig equals the model.
- Fail: same config, one cut_resp bit inverted on pattern 7 → out=0, bist_end=1.
- Start handling:
  - start held high for 2 cycles → exactly one run;
  - start edges during RUN → ignored, timing unchanged;
  - start edge in DONE → bist_end drops next cycle, and the second run gives the same result.
- Reset: rst asserted mid-RUN → all outputs 0 asynchronously. start held high across reset release → no run until start goes low then high.
